// File: rtl/digital_word_packer_pkg.sv
// Shared types and default parameters for the bit-to-word packer family.
package digital_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2
    } pack_state_t;

    localparam int DEF_WORD_W      = 12;
    localparam int DEF_FRAME_BITS  = 10416;
    localparam int DEF_LEVEL_W     = 15;
    localparam int DEF_READY_LEN   = 6;
    localparam int DEF_MSB_FIRST   = 1;
    localparam int DEF_SYNC_STAGES = 3;

    typedef logic [DEF_LEVEL_W-1:0] fill_level_t;

endpackage

// File: rtl/digital_word_packer_req_edge_sync.sv
// Multi-flop synchroniser for an asynchronous request line with a rising-edge detector.
module req_edge_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async_req,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async_req};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/digital_word_packer.sv
// Packs FIFO bits (or zeros when no frame is armed) into one word per request edge.
//   state | meaning
//   IDLE  | waiting for a synchronised request edge
//   FILL  | two cycles per bit: A pops/shifts, B advances the bit index
//   SEND  | word published, data_ready held for READY_LEN cycles
module digital_word_packer
    import digital_packer_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int READY_LEN   = DEF_READY_LEN,
    parameter int MSB_FIRST   = DEF_MSB_FIRST,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_bit_data,
    input  logic [LEVEL_W-1:0] i_bits_used,
    output logic               o_bit_request,
    input  logic               i_data_request,
    output logic [WORD_W-1:0]  o_data,
    output logic               o_data_ready,
    output logic               o_frame_active,
    output logic               o_frame_done,
    output logic               o_req_overrun
);

    localparam int                 IDX_W      = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(WORD_W - 1);
    localparam logic [LEVEL_W-1:0] FRAME_LEN  = LEVEL_W'(FRAME_BITS);
    localparam logic [LEVEL_W-1:0] FRAME_LAST = LEVEL_W'(FRAME_BITS - 1);
    localparam logic [3:0]         READY_LOAD = 4'(READY_LEN - 1);

    pack_state_t        r_state;
    pack_state_t        w_next_state;
    logic               r_phase;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [LEVEL_W-1:0] r_frame_cnt;
    logic               r_armed;
    logic [WORD_W-1:0]  r_shift;
    logic [WORD_W-1:0]  r_data;
    logic [3:0]         r_ready_cnt;
    logic               r_overrun;

    logic              w_rise;
    logic              w_arm;
    logic              w_pop;
    logic              w_last_pop;
    logic              w_bit_in;
    logic              w_word_end;
    logic [WORD_W-1:0] w_shift_next;

    req_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk         (clk),
        .reset       (reset),
        .i_async_req (i_data_request),
        .o_rise      (w_rise)
    );

    always_comb begin
        w_next_state = r_state;
        w_arm        = (r_state == ST_IDLE) && w_rise && !r_armed && (i_bits_used >= FRAME_LEN);
        w_pop        = (r_state == ST_FILL) && !r_phase && r_armed;
        w_last_pop   = w_pop && (r_frame_cnt == FRAME_LAST);
        w_bit_in     = w_pop & i_bit_data;
        w_word_end   = (r_state == ST_FILL) && r_phase && (r_bit_idx == LAST_IDX);
        // Disarmed cycles shift in zero, which also pads the tail of a frame.
        if (MSB_FIRST != 0) begin
            w_shift_next = {r_shift[WORD_W-2:0], w_bit_in};
        end else begin
            w_shift_next = {w_bit_in, r_shift[WORD_W-1:1]};
        end

        case (r_state)
            ST_IDLE: if (w_rise) w_next_state = ST_FILL;
            ST_FILL: if (w_word_end) w_next_state = ST_SEND;
            ST_SEND: if (r_ready_cnt == 4'd0) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase     <= 1'b0;
            r_bit_idx   <= '0;
            r_frame_cnt <= '0;
            r_armed     <= 1'b0;
            r_shift     <= '0;
            r_data      <= '0;
            r_ready_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_rise && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_phase   <= 1'b0;
                        r_bit_idx <= '0;
                        r_shift   <= '0;
                    end
                    if (w_arm) begin
                        r_armed     <= 1'b1;
                        r_frame_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        r_shift <= w_shift_next;
                        if (w_pop) r_frame_cnt <= r_frame_cnt + 1'b1;
                        if (w_last_pop) r_armed <= 1'b0;
                    end else begin
                        r_phase <= 1'b0;
                        if (w_word_end) begin
                            r_bit_idx   <= '0;
                            r_data      <= r_shift;
                            r_ready_cnt <= READY_LOAD;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (r_ready_cnt != 4'd0) r_ready_cnt <= r_ready_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_bit_request  = w_pop;
    assign o_frame_done   = w_last_pop;
    assign o_data         = r_data;
    assign o_data_ready   = (r_state == ST_SEND);
    assign o_frame_active = r_armed;
    assign o_req_overrun  = r_overrun;

endmodule

// File: tb/tb_digital_word_packer.sv
// Two packers share clock/reset/request: u_a at defaults, u_b with an 18-bit frame and LSB-first order.
// Each has its own show-ahead FIFO model; expected words come from a queue-based frame model.
module tb_digital_word_packer;
    import digital_packer_pkg::*;

    localparam int W    = 12;
    localparam int RLEN = 6;

    typedef struct {
        logic [W-1:0] push;
        int           push_n;
        int           lvl_a;
        int           lvl_b;
        logic [W-1:0] e_a;
        logic [W-1:0] e_b;
        int           p_a;
        int           p_b;
        int           d_a;
        int           d_b;
        logic         act_a;
        logic         act_b;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_request;
    fill_level_t  lvl [2];
    logic         bit_data [2];
    logic         br [2];
    logic         rdy [2];
    logic         act [2];
    logic         done [2];
    logic         ovr [2];
    logic [W-1:0] dat [2];

    logic fa [2][1024];
    int   wp [2] = '{0, 0};
    int   rp [2] = '{0, 0};

    int   cyc = 0;
    int   tot_pops [2] = '{0, 0};
    int   tot_done [2] = '{0, 0};
    int   tot_ovr  [2] = '{0, 0};
    int   tot_pub  [2] = '{0, 0};
    int   bad_gap  [2] = '{0, 0};
    int   last_pop [2] = '{-100, -100};
    int   run      [2] = '{0, 0};
    int   last_run [2] = '{0, 0};
    logic rdy_q    [2] = '{1'b0, 1'b0};

    bit   mq0 [$];
    bit   mq1 [$];
    bit   m_armed [2] = '{1'b0, 1'b0};
    int   m_cnt   [2] = '{0, 0};

    int   checks   = 0;
    int   failures = 0;

    vec_t tbl [4];

    digital_word_packer u_a (
        .clk            (clk),
        .reset          (reset),
        .i_bit_data     (bit_data[0]),
        .i_bits_used    (lvl[0]),
        .o_bit_request  (br[0]),
        .i_data_request (data_request),
        .o_data         (dat[0]),
        .o_data_ready   (rdy[0]),
        .o_frame_active (act[0]),
        .o_frame_done   (done[0]),
        .o_req_overrun  (ovr[0])
    );

    digital_word_packer #(
        .FRAME_BITS (18),
        .MSB_FIRST  (0)
    ) u_b (
        .clk            (clk),
        .reset          (reset),
        .i_bit_data     (bit_data[1]),
        .i_bits_used    (lvl[1]),
        .o_bit_request  (br[1]),
        .i_data_request (data_request),
        .o_data         (dat[1]),
        .o_data_ready   (rdy[1]),
        .o_frame_active (act[1]),
        .o_frame_done   (done[1]),
        .o_req_overrun  (ovr[1])
    );

    always #5 clk = ~clk;

    assign bit_data[0] = (rp[0] < wp[0]) ? fa[0][rp[0] % 1024] : 1'b0;
    assign bit_data[1] = (rp[1] < wp[1]) ? fa[1][rp[1] % 1024] : 1'b0;

    always @(posedge clk) begin
        if (br[0]) rp[0] <= rp[0] + 1;
        if (br[1]) rp[1] <= rp[1] + 1;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            rdy_q[d] <= rdy[d];
            if (rdy[d] && !rdy_q[d]) tot_pub[d] <= tot_pub[d] + 1;
            if (rdy[d]) begin
                run[d] <= run[d] + 1;
            end else begin
                run[d] <= 0;
                if (run[d] != 0) last_run[d] <= run[d];
            end
            if (done[d]) tot_done[d] <= tot_done[d] + 1;
            if (ovr[d])  tot_ovr[d]  <= tot_ovr[d] + 1;
            if (br[d]) begin
                tot_pops[d] <= tot_pops[d] + 1;
                if ((cyc - last_pop[d]) < 4 && (cyc - last_pop[d]) != 2) bad_gap[d] <= bad_gap[d] + 1;
                last_pop[d] <= cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_bits(input logic [W-1:0] v, input int n, input bit to_model);
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < 2; d++) begin
                fa[d][wp[d] % 1024] = v[W-1-i];
                wp[d] = wp[d] + 1;
            end
            if (to_model) begin
                mq0.push_back(v[W-1-i]);
                mq1.push_back(v[W-1-i]);
            end
        end
    endtask

    function automatic int frame_len(input int d);
        return (d == 0) ? 10416 : 18;
    endfunction

    function automatic bit model_pop(input int d);
        bit b;
        b = 1'b0;
        if (d == 0) begin
            if (mq0.size() > 0) b = mq0.pop_front();
        end else begin
            if (mq1.size() > 0) b = mq1.pop_front();
        end
        return b;
    endfunction

    // One word as the frame rules describe it: arm at word start, take FIFO bits while armed, zeros after.
    task automatic model_word(input int d, input int level, output logic [W-1:0] w,
                              output int pops, output int dones);
        bit b;
        w     = '0;
        pops  = 0;
        dones = 0;
        if (!m_armed[d] && level >= frame_len(d)) begin
            m_armed[d] = 1'b1;
            m_cnt[d]   = 0;
        end
        for (int i = 0; i < W; i++) begin
            b = 1'b0;
            if (m_armed[d]) begin
                b = model_pop(d);
                pops++;
                m_cnt[d]++;
                if (m_cnt[d] == frame_len(d)) begin
                    m_armed[d] = 1'b0;
                    dones++;
                end
            end
            if (d == 0) w[W-1-i] = b;
            else        w[i]     = b;
        end
    endtask

    task automatic exercise(input string tag, input int ovr_gap,
                            input logic [W-1:0] e_a, input logic [W-1:0] e_b,
                            input int p_a, input int p_b, input int d_a, input int d_b,
                            input logic a_a, input logic a_b);
        int           pops0 [2];
        int           done0 [2];
        int           ovr0  [2];
        int           pub0  [2];
        int           gap0  [2];
        logic [W-1:0] ew    [2];
        int           ep    [2];
        int           ed    [2];
        logic         ea    [2];
        int           k;
        ew[0] = e_a; ew[1] = e_b;
        ep[0] = p_a; ep[1] = p_b;
        ed[0] = d_a; ed[1] = d_b;
        ea[0] = a_a; ea[1] = a_b;
        for (int d = 0; d < 2; d++) begin
            pops0[d] = tot_pops[d];
            done0[d] = tot_done[d];
            ovr0[d]  = tot_ovr[d];
            pub0[d]  = tot_pub[d];
            gap0[d]  = bad_gap[d];
        end
        @(negedge clk);
        data_request = 1'b1;
        repeat (3) @(negedge clk);
        data_request = 1'b0;
        if (ovr_gap > 0) begin
            repeat (ovr_gap - 3) @(negedge clk);
            data_request = 1'b1;
            repeat (3) @(negedge clk);
            data_request = 1'b0;
        end
        k = 0;
        while (tot_pub[0] == pub0[0] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_publish_wait"}, 32'(k < 100), 32'd1);
        k = 0;
        while (rdy[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready_wait"}, 32'(k < 40), 32'd1);
        repeat ((ovr_gap > 0) ? 45 : 3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_data%0d", tag, d), 32'(dat[d]), 32'(ew[d]));
            chk($sformatf("%s_ready_len%0d", tag, d), last_run[d], RLEN);
            chk($sformatf("%s_pops%0d", tag, d), tot_pops[d] - pops0[d], ep[d]);
            chk($sformatf("%s_frame_done%0d", tag, d), tot_done[d] - done0[d], ed[d]);
            chk($sformatf("%s_frame_active%0d", tag, d), 32'(act[d]), 32'(ea[d]));
            chk($sformatf("%s_pop_spacing%0d", tag, d), bad_gap[d] - gap0[d], 0);
            chk($sformatf("%s_overrun%0d", tag, d), tot_ovr[d] - ovr0[d], (ovr_gap > 0) ? 1 : 0);
            chk($sformatf("%s_publishes%0d", tag, d), tot_pub[d] - pub0[d], 1);
        end
    endtask

    initial begin
        logic [W-1:0] ew [2];
        int           ep [2];
        int           ed [2];
        int           k;
        int           p0;

        reset        = 1'b0;
        data_request = 1'b0;
        lvl[0]       = '0;
        lvl[1]       = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state_a", 32'({dat[0], rdy[0], br[0], act[0], done[0], ovr[0]}), 32'd0);
        chk("reset_state_b", 32'({dat[1], rdy[1], br[1], act[1], done[1], ovr[1]}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // push, push_n, lvl_a, lvl_b, e_a, e_b, pops a/b, frame_done a/b, frame_active a/b
        tbl[0] = '{12'h000, 0,  0,     0,  12'h000, 12'h000, 0,  0,  0, 0, 1'b0, 1'b0};
        tbl[1] = '{12'hA5C, 12, 10417, 20, 12'hA5C, 12'h3A5, 12, 12, 0, 0, 1'b1, 1'b1};
        tbl[2] = '{12'hB37, 12, 10417, 20, 12'hB37, 12'h00D, 12, 6,  0, 1, 1'b1, 1'b0};
        tbl[3] = '{12'h5E1, 12, 10417, 10, 12'h5E1, 12'h000, 12, 0,  0, 0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            push_bits(tbl[i].push, tbl[i].push_n, 1'b0);
            lvl[0] = fill_level_t'(tbl[i].lvl_a);
            lvl[1] = fill_level_t'(tbl[i].lvl_b);
            exercise($sformatf("vec%0d", i), 0, tbl[i].e_a, tbl[i].e_b, tbl[i].p_a, tbl[i].p_b,
                     tbl[i].d_a, tbl[i].d_b, tbl[i].act_a, tbl[i].act_b);
        end

        // Reset in the middle of FILL, then a clean word afterwards.
        lvl[0] = fill_level_t'(10417);
        lvl[1] = fill_level_t'(20);
        push_bits(12'h9E3, 12, 1'b0);
        p0 = tot_pops[0];
        @(negedge clk);
        data_request = 1'b1;
        repeat (3) @(negedge clk);
        data_request = 1'b0;
        k = 0;
        while ((tot_pops[0] - p0) < 3 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("midfill_reach", 32'(k < 60), 32'd1);
        reset = 1'b0;
        #1;
        chk("midfill_reset_a", 32'({dat[0], rdy[0], br[0], act[0], done[0], ovr[0]}), 32'd0);
        chk("midfill_reset_b", 32'({dat[1], rdy[1], br[1], act[1], done[1], ovr[1]}), 32'd0);
        wp[0] = rp[0];
        wp[1] = rp[1];
        mq0.delete();
        mq1.delete();
        m_armed[0] = 1'b0;
        m_armed[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        push_bits(12'h6C9, 12, 1'b1);
        model_word(0, int'(lvl[0]), ew[0], ep[0], ed[0]);
        model_word(1, int'(lvl[1]), ew[1], ep[1], ed[1]);
        exercise("post_reset", 0, ew[0], ew[1], ep[0], ep[1], ed[0], ed[1], m_armed[0], m_armed[1]);

        push_bits(12'h3D4, 12, 1'b1);
        model_word(0, int'(lvl[0]), ew[0], ep[0], ed[0]);
        model_word(1, int'(lvl[1]), ew[1], ep[1], ed[1]);
        exercise("overrun", 10, ew[0], ew[1], ep[0], ep[1], ed[0], ed[1], m_armed[0], m_armed[1]);

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            push_bits(v, 12, 1'b1);
            if ($urandom_range(0, 3) == 0) lvl[0] = fill_level_t'($urandom_range(0, 10415));
            else                           lvl[0] = fill_level_t'($urandom_range(10416, 32767));
            lvl[1] = fill_level_t'($urandom_range(0, 30));
            model_word(0, int'(lvl[0]), ew[0], ep[0], ed[0]);
            model_word(1, int'(lvl[1]), ew[1], ep[1], ed[1]);
            exercise($sformatf("rnd%0d", n), 0, ew[0], ew[1], ep[0], ep[1], ed[0], ed[1],
                     m_armed[0], m_armed[1]);
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
